fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: Thumb halfword fetch with credit-limited memory requests, in-order buffer and redirect drop
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        take_branch_i,
  input  logic        flush_pipeline_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic        imem_rvalid_i,
  input  logic [15:0] imem_rdata_i,
  output logic [15:0] instruction_o,
  output logic [31:0] program_counter_o,
  output logic        is_valid_o
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state;
  logic [31:0] fetch_pc;
  logic [CW-1:0] outstanding, drop_count, occupancy, out_after_rsp;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [15:0] buf_instr [BUF_DEPTH];
  logic [31:0] buf_addr [BUF_DEPTH];
  logic redirect, accept, drop, push, pop;
  logic [31:0] rsp_addr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(BUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    redirect = take_branch_i | flush_pipeline_i;
    imem_req_o = state == FETCH && !redirect &&
                 ((CW+1)'(outstanding) + (CW+1)'(occupancy) < (CW+1)'(BUF_DEPTH));
    imem_addr_o = fetch_pc;
    accept = imem_req_o & imem_ack_i;
    drop = imem_rvalid_i && drop_count != '0;
    push = imem_rvalid_i && drop_count == '0 && !redirect;
    is_valid_o = occupancy != '0 && !redirect;
    pop = is_valid_o && !stall_i;
    out_after_rsp = (imem_rvalid_i && outstanding != '0) ? outstanding - 1'b1 : outstanding;
    // once drops are done, every outstanding request is contiguous and ends just below fetch_pc
    rsp_addr = fetch_pc - (32'(outstanding) << 1);
    instruction_o = occupancy != '0 ? buf_instr[rd_ptr] : '0;
    program_counter_o = occupancy != '0 ? buf_addr[rd_ptr] + 32'd4 : '0;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      outstanding <= '0;
      drop_count <= '0;
      occupancy <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= FETCH;
      if (redirect) begin
        fetch_pc <= branch_target_i & ~32'd1;
        outstanding <= out_after_rsp;
        drop_count <= out_after_rsp;
        occupancy <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd2;
        outstanding <= out_after_rsp + CW'(accept);
        if (drop) drop_count <= drop_count - 1'b1;
        if (push) wr_ptr <= inc(wr_ptr);
        if (pop) rd_ptr <= inc(rd_ptr);
        occupancy <= occupancy + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata_i;
      buf_addr[wr_ptr] <= rsp_addr;
    end
  end
  no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(imem_rvalid_i && !redirect && drop_count == '0 && occupancy == CW'(BUF_DEPTH)));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with a variable-latency in-order memory model
module tb_fetch_unit;
  logic clk = 0, rst = 1, take_branch = 0, flush = 0, stall = 0, ack = 0, rvalid = 0, inject = 0;
  logic [31:0] target = '0, addr, pc, ea;
  logic [15:0] rdata = '0, instr;
  logic req, valid, prev_req = 0, prev_ack = 0;
  logic [31:0] prev_addr = '0;
  int checks = 0, errors = 0, lat = 1, cyc = 0, pops = 0;
  typedef struct {int due; logic [31:0] a;} rsp_t;
  rsp_t mq[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i(clk), .reset_i(rst), .take_branch_i(take_branch), .flush_pipeline_i(flush),
    .branch_target_i(target), .stall_i(stall), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instruction_o(instr), .program_counter_o(pc), .is_valid_o(valid)
  );

  function automatic logic [15:0] mem_data(input logic [31:0] a);
    return a[16:1] ^ 16'h5A3C;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      rvalid <= 0;
      rdata <= '0;
    end else begin
      cyc++;
      if (req && ack) mq.push_back('{cyc + lat - 1, addr});
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        rvalid <= 1;
        rdata <= mem_data(mq[0].a);
        void'(mq.pop_front());
      end else begin
        rvalid <= inject;
        rdata <= 16'hDEAD;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_req = 0;
    end else begin
      if (prev_req && !prev_ack && !(take_branch || flush)) begin
        checks++;
        if (!req || addr !== prev_addr) begin
          errors++;
          $display("FAIL req_stable: req=%b addr=%h expected req=1 addr=%h", req, addr, prev_addr);
        end
      end
      if (take_branch || flush) begin
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL redirect_valid: is_valid_o=%b expected 0", valid);
        end
        exp_q.delete();
      end else begin
        if (valid && !stall) begin
          checks++;
          pops++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: pc=%h instr=%h with nothing expected", pc, instr);
          end else begin
            ea = exp_q.pop_front();
            if (instr !== mem_data(ea) || pc !== ea + 32'd4) begin
              errors++;
              $display("FAIL sb_data: instr=%h pc=%h expected instr=%h pc=%h", instr, pc, mem_data(ea), ea + 32'd4);
            end
          end
        end
        if (req && ack) exp_q.push_back(addr);
      end
      prev_req = req;
      prev_ack = ack;
      prev_addr = addr;
    end
  end

  task automatic apply_reset;
    @(posedge clk); #1;
    rst = 1; take_branch = 0; flush = 0; inject = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (req !== 0 || valid !== 0 || instr !== 16'h0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b valid=%b instr=%h pc=%h expected all 0", req, valid, instr, pc);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if (req !== 0) begin
      errors++;
      $display("FAIL idle_no_req: req=%b expected 0", req);
    end
  endtask

  task automatic test_basic;
    int n_acc = 0, t_acc = -1, t_val = -1;
    logic [31:0] acc [3];
    logic [31:0] vpc = '0;
    lat = 1; ack = 1; stall = 0;
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req && ack && n_acc < 3) begin
        if (n_acc == 0) t_acc = i;
        acc[n_acc] = addr;
        n_acc++;
      end
      if (valid && t_val < 0) begin
        t_val = i;
        vpc = pc;
      end
    end
    checks++;
    if (n_acc != 3) begin
      errors++;
      $display("FAIL basic_accepts: got %0d expected 3", n_acc);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (acc[k] !== 32'(2 * k)) begin
        errors++;
        $display("FAIL basic_addr%0d: got %h expected %h", k, acc[k], 32'(2 * k));
      end
    end
    checks++;
    if (t_val - t_acc != 2) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 2", t_val - t_acc);
    end
    checks++;
    if (vpc !== 32'h4) begin
      errors++;
      $display("FAIL basic_first_pc: got %h expected 00000004", vpc);
    end
  endtask

  task automatic test_stall;
    int n_acc = 0;
    lat = 1; ack = 1; stall = 1;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req && ack) n_acc++;
      if (valid) begin
        checks++;
        if (pc !== 32'h4 || instr !== mem_data(32'h0)) begin
          errors++;
          $display("FAIL stall_head: pc=%h instr=%h expected 00000004 %h", pc, instr, mem_data(32'h0));
        end
      end
    end
    checks++;
    if (n_acc != 2 || req !== 0 || valid !== 1) begin
      errors++;
      $display("FAIL stall_credit: accepts=%0d req=%b valid=%b expected 2 0 1", n_acc, req, valid);
    end
    @(posedge clk); #1;
    stall = 0;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_branch;
    int n_acc = 0;
    logic got_acc = 0, got_val = 0;
    lat = 3; ack = 1; stall = 0;
    apply_reset();
    for (int i = 0; i < 20 && n_acc < 2; i++) begin
      @(negedge clk);
      if (req && ack) n_acc++;
    end
    @(posedge clk); #1;
    take_branch = 1; target = 32'h100;
    @(negedge clk);
    checks++;
    if (req !== 0 || valid !== 0) begin
      errors++;
      $display("FAIL branch_cycle: req=%b valid=%b expected 0 0", req, valid);
    end
    @(posedge clk); #1;
    take_branch = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req && ack && !got_acc) begin
        got_acc = 1;
        checks++;
        if (addr !== 32'h100) begin
          errors++;
          $display("FAIL branch_addr: got %h expected 00000100", addr);
        end
      end
      if (valid && !got_val) begin
        got_val = 1;
        checks++;
        if (pc !== 32'h104) begin
          errors++;
          $display("FAIL branch_pc: got %h expected 00000104", pc);
        end
      end
    end
    checks++;
    if (!got_acc || !got_val) begin
      errors++;
      $display("FAIL branch_timeout: accept=%b valid=%b expected 1 1", got_acc, got_val);
    end
  endtask

  task automatic test_redirect_full;
    logic got_val = 0;
    lat = 1; ack = 1; stall = 1;
    apply_reset();
    repeat (10) @(posedge clk);
    #1 inject = 1;
    @(posedge clk); #1;
    inject = 0; flush = 1; target = 32'h200;
    @(negedge clk);
    checks++;
    if (valid !== 0 || rvalid !== 1) begin
      errors++;
      $display("FAIL full_redirect: valid=%b rvalid=%b expected 0 1", valid, rvalid);
    end
    @(posedge clk); #1;
    flush = 0; stall = 0;
    for (int i = 0; i < 20 && !got_val; i++) begin
      @(negedge clk);
      if (valid) begin
        got_val = 1;
        checks++;
        if (pc !== 32'h204) begin
          errors++;
          $display("FAIL full_next_pc: got %h expected 00000204", pc);
        end
      end
    end
    checks++;
    if (!got_val) begin
      errors++;
      $display("FAIL full_timeout: no valid after redirect");
    end
  endtask

  task automatic test_ack_low;
    logic [31:0] a0 = '1;
    lat = 1; ack = 0; stall = 0;
    apply_reset();
    for (int i = 0; i < 5 && !req; i++) @(negedge clk);
    a0 = addr;
    checks++;
    if (!req || a0 !== 32'h0) begin
      errors++;
      $display("FAIL ack_first: req=%b addr=%h expected 1 00000000", req, a0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (req !== 1 || addr !== a0) begin
        errors++;
        $display("FAIL ack_hold: req=%b addr=%h expected 1 %h", req, addr, a0);
      end
    end
    @(posedge clk); #1;
    ack = 1;
    @(posedge clk); #1;
    ack = 0;
    @(negedge clk);
    checks++;
    if (req !== 1 || addr !== a0 + 32'd2) begin
      errors++;
      $display("FAIL ack_advance: req=%b addr=%h expected 1 %h", req, addr, a0 + 32'd2);
    end
    ack = 1;
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    logic got_acc = 0, got_val = 0;
    lat = 2; ack = 1; stall = 0;
    apply_reset();
    repeat (6) @(posedge clk);
    #3 rst = 1;
    #1;
    checks++;
    if (req !== 0 || valid !== 0 || instr !== 16'h0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs: req=%b valid=%b instr=%h pc=%h expected all 0", req, valid, instr, pc);
    end
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 20 && !got_val; i++) begin
      @(negedge clk);
      if (req && ack && !got_acc) begin
        got_acc = 1;
        checks++;
        if (addr !== 32'h0) begin
          errors++;
          $display("FAIL midreset_addr: got %h expected 00000000", addr);
        end
      end
      if (valid) begin
        got_val = 1;
        checks++;
        if (pc !== 32'h4 || instr !== mem_data(32'h0)) begin
          errors++;
          $display("FAIL midreset_first: pc=%h instr=%h expected 00000004 %h", pc, instr, mem_data(32'h0));
        end
      end
    end
    checks++;
    if (!got_val) begin
      errors++;
      $display("FAIL midreset_timeout: no valid after reset");
    end
  endtask

  task automatic test_wrap;
    int n = 0;
    logic [31:0] pcs [2];
    lat = 1; ack = 1; stall = 0;
    apply_reset();
    flush = 1; target = 32'hFFFF_FFFD;
    @(posedge clk); #1;
    flush = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge clk);
      if (valid) begin
        pcs[n] = pc;
        n++;
      end
    end
    checks++;
    if (n != 2 || pcs[0] !== 32'h0 || pcs[1] !== 32'h2) begin
      errors++;
      $display("FAIL wrap_pc: n=%0d pc0=%h pc1=%h expected 2 00000000 00000002", n, pcs[0], pcs[1]);
    end
  endtask

  task automatic test_random;
    int p0;
    lat = 2; stall = 0; ack = 1;
    apply_reset();
    p0 = pops;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      ack = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 3) == 0;
      take_branch = $urandom_range(0, 29) == 0;
      flush = $urandom_range(0, 29) == 0;
      target = $urandom;
    end
    @(posedge clk); #1;
    take_branch = 0; flush = 0; stall = 0; ack = 1;
    repeat (10) @(posedge clk);
    checks++;
    if (pops - p0 < 50) begin
      errors++;
      $display("FAIL random_progress: %0d pops expected at least 50", pops - p0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_branch();
    test_redirect_full();
    test_ack_low();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
